lut_bist_ctrl: RTL and testbench
================================

LUT_BIST_CTRL -- requirements
Module: lut_bist_ctrl

Interface
REQ-001 Parameter LUT_K, default 2: LUT input count; legal range 1..6.
REQ-002 Parameter SETTLE_CYCLES, default 4: wait cycles after each new input vector before sampling; legal range 1..255.
REQ-003 Parameter EXPECTED, default 4'b1010, width 2**LUT_K: golden truth table; bit n is the expected LUT output for input vector n.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 start  input  1  level sampled each edge; begins a sweep when sampled high in IDLE.
REQ-007 abort  input  1  terminates a sweep in progress.
REQ-008 lut_i  output  LUT_K  input vector driven into the LUT under test; registered.
REQ-009 lut_o  input  1  LUT under test output; treated as asynchronous to the sweep until sampled.
REQ-010 busy  output  1  high in SETTLE and SAMPLE.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches; held until the next start or abort.
REQ-013 result  output  2**LUT_K  captured truth table; bit n holds lut_o sampled for vector n.
REQ-014 err_cnt  output  LUT_K+1  count of mismatching vectors in the current or last sweep; saturates at 2**LUT_K.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 IDLE with start=1 and abort=0: next edge sets idx=0, lut_i=0, settle counter=SETTLE_CYCLES-1, result=0, err_cnt=0, pass=0, and moves to SETTLE.
REQ-017 SETTLE: decrement the counter each edge; at 0, move to SAMPLE; lut_i SHALL stay stable.
REQ-018 SAMPLE: write lut_o into result[idx]; increment err_cnt if lut_o!=EXPECTED[idx]; if idx=2**LUT_K-1, go to DONE; otherwise idx+=1, lut_i=idx+1, reload counter, go to SETTLE.
REQ-019 Each vector SHALL take exactly SETTLE_CYCLES+1 cycles.
REQ-020 done SHALL be high only during the cycle after the (2**LUT_K)*(SETTLE_CYCLES+1)-th rising edge following the edge that samples start.
REQ-021 DONE: done=1 and pass=(final err_cnt==0), including the final sample; next edge goes to IDLE; lut_i returns to 0.
REQ-022 start sampled outside IDLE SHALL be ignored; start held high SHALL begin a new sweep from IDLE, one cycle after DONE.
REQ-023 abort sampled high in SETTLE or SAMPLE: next edge goes to IDLE, lut_i=0, pass=0; done is not pulsed; result and err_cnt keep their partial values.
REQ-024 abort and start both high in IDLE: abort wins and no sweep starts; abort in DONE is ignored.
REQ-025 lut_o SHALL be used only in SAMPLE.

Reset
REQ-026 rst_n low SHALL force the following immediately, regardless of clk: state=IDLE, lut_i=0, busy=0, done=0, pass=0, result=0, err_cnt=0, idx=0, counter=0.
REQ-027 Reset deassertion mid-sweep SHALL leave the block in IDLE awaiting start; no partial sweep resumes.

Structure
REQ-028 Package lut_bist_pkg SHALL hold the state enum, the default constants for LUT_K, SETTLE_CYCLES and EXPECTED, and a function computing the vector count (2**LUT_K).
REQ-029 The settle down-counter with load, decrement and zero flag SHALL be the sub-module lut_bist_settle_cnt; everything else stays in lut_bist_ctrl.

Verification
REQ-030 Defaults, LUT modelled as lut_o=lut_i[0], start pulsed once -> lut_i steps 00,01,10,11, each held 5 cycles; done high in the cycle after edge 20; pass=1; result=4'b1010; err_cnt=0.
REQ-031 Defaults, LUT modelled as lut_o=lut_i[1] -> result=4'b1100, err_cnt=2, pass=0, done at the same cycle as REQ-030.
REQ-032 Defaults, abort during vector 2 SETTLE -> IDLE next edge, lut_i=0, no done pulse, pass=0, result[1:0]=2'b10.
REQ-033 rst_n low asynchronously mid-SAMPLE -> all outputs 0 before the next clk edge; after release, start runs a full clean sweep with pass=1.
REQ-034 start held high continuously -> back-to-back sweeps with exactly one IDLE cycle between a done pulse and the next lut_i=0 vector; start pulsed while busy has no effect.
REQ-035 LUT_K=3, SETTLE_CYCLES=1, EXPECTED=8'h96, XOR3 model -> 16-cycle sweep, pass=1, result=8'h96.

Source files
------------

// File: rtl/lut_bist_pkg.sv
// Shared types and defaults for the LUT truth-table self-test controller.
// Holds the FSM state enum, default parameters and the vector-count helper.
package lut_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned DEF_LUT_K         = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam logic [3:0]  DEF_EXPECTED      = 4'b1010;

    // Wide enough for the largest settle count (255).
    localparam int unsigned CNT_W = 8;

    function automatic int unsigned vec_count(input int unsigned k);
        return 32'd1 << k;
    endfunction

endpackage

// File: rtl/lut_bist_settle_cnt.sv
// Settle down-counter: load, decrement, zero flag.
// Ports: clk, rst_n, load, dec, load_val -> zero.
module lut_bist_settle_cnt
    import lut_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lut_bist_ctrl.sv
// LUT BIST controller: sweeps every input vector, samples the LUT output,
// and compares against a golden table. Ports: clk, rst_n, start, abort,
// lut_o in; lut_i, busy, done, pass, result, err_cnt out.
module lut_bist_ctrl
    import lut_bist_pkg::*;
#(
    parameter int unsigned           LUT_K         = DEF_LUT_K,
    parameter int unsigned           SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [2**LUT_K-1:0]   EXPECTED      = DEF_EXPECTED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [LUT_K-1:0]     lut_i,
    input  logic                 lut_o,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**LUT_K-1:0]  result,
    output logic [LUT_K:0]       err_cnt
);

    localparam int unsigned      VEC     = vec_count(LUT_K);
    localparam logic [LUT_K-1:0] LAST    = LUT_K'(VEC - 1);
    localparam logic [LUT_K:0]   ERR_MAX = (LUT_K + 1)'(VEC);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [LUT_K-1:0] idx;
    logic             go;
    logic             stop;
    logic             smp;
    logic             last;
    logic             miss;
    logic [LUT_K:0]   err_inc;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign last     = (idx == LAST);
    assign miss     = (lut_o != EXPECTED[idx]);
    assign err_inc  = (miss && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;
    assign cnt_load = go || (smp && !last);
    assign cnt_dec  = (state == SETTLE) && !abort;

    lut_bist_settle_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (RELOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (go) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (abort)         state_nxt = IDLE;
                else if (cnt_zero) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
                else           state_nxt = SETTLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // abort outranks start in IDLE; abort in DONE is ignored.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        go   = 1'b0;
        stop = 1'b0;
        smp  = 1'b0;
        unique case (state)
            IDLE:   go = start && !abort;
            SETTLE: begin
                busy = 1'b1;
                stop = abort;
            end
            SAMPLE: begin
                busy = 1'b1;
                stop = abort;
                smp  = !abort;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // lut_o is only consumed through smp, i.e. in SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            lut_i   <= '0;
            result  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (go) begin
            idx     <= '0;
            lut_i   <= '0;
            result  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (stop) begin
            lut_i <= '0;
            pass  <= 1'b0;
        end else if (smp) begin
            result[idx] <= lut_o;
            err_cnt     <= err_inc;
            if (last) begin
                pass <= (err_inc == '0);
            end else begin
                idx   <= idx + 1'b1;
                lut_i <= idx + 1'b1;
            end
        end else if (state == DONE) begin
            lut_i <= '0;
        end
    end

endmodule

// File: tb/tb_lut_bist_ctrl.sv
// Testbench for lut_bist_ctrl: sweep-level reference model plus directed
// literal checks, random start/abort traffic and an XOR3 configuration.
module tb_lut_bist_ctrl;

    localparam int S   = 4;
    localparam int VEC = 4;
    localparam logic [3:0] EXP0 = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic [1:0] lut_i0;
    logic       lut_o0;
    logic       busy0, done0, pass0;
    logic [3:0] result0;
    logic [2:0] err0;
    logic [3:0] tt0 = 4'b1010;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [2:0] lut_i1;
    logic       lut_o1;
    logic       busy1, done1, pass1;
    logic [7:0] result1;
    logic [3:0] err1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign lut_o0 = tt0[lut_i0];
    assign lut_o1 = ^lut_i1;

    lut_bist_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .lut_i(lut_i0), .lut_o(lut_o0), .busy(busy0), .done(done0),
        .pass(pass0), .result(result0), .err_cnt(err0)
    );

    lut_bist_ctrl #(.LUT_K(3), .SETTLE_CYCLES(1), .EXPECTED(8'h96)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .lut_i(lut_i1), .lut_o(lut_o1), .busy(busy1), .done(done1),
        .pass(pass1), .result(result1), .err_cnt(err1)
    );

    // Reference model: a sweep is a count of cycles since start; every
    // (S+1)-th cycle is a sample of vector t/(S+1).
    bit         m_act, m_done, m_pass;
    int         m_t;
    logic [3:0] m_res;
    logic [2:0] m_err;
    logic [1:0] m_lut;

    always @(posedge clk or negedge rst_n) begin
        int   v;
        logic lo;
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_pass = 0; m_t = 0;
            m_res = '0; m_err = '0; m_lut = '0;
        end else if (m_done) begin
            m_done = 0;
            m_lut  = '0;
        end else if (!m_act) begin
            if (start0 && !abort0) begin
                m_act = 1; m_t = 0; m_lut = '0;
                m_res = '0; m_err = '0; m_pass = 0;
            end
        end else if (abort0) begin
            m_act = 0; m_lut = '0; m_pass = 0;
        end else begin
            v = m_t / (S + 1);
            if (m_t % (S + 1) == S) begin
                lo = tt0[m_lut];
                m_res[v] = lo;
                if (lo != EXP0[v]) m_err = m_err + 3'd1;
                if (v == VEC - 1) begin
                    m_act = 0; m_done = 1; m_pass = (m_err == 0);
                end else begin
                    m_lut = 2'(v + 1);
                end
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if (busy0 === m_act && done0 === m_done && pass0 === m_pass &&
                result0 === m_res && err0 === m_err && lut_i0 === m_lut)
                n_pass++;
            else
                $display("FAIL cycle_cmp t=%0t got b=%b d=%b p=%b r=%b e=%0d i=%0d required b=%b d=%b p=%b r=%b e=%0d i=%0d",
                         $time, busy0, done0, pass0, result0, err0, lut_i0,
                         m_act, m_done, m_pass, m_res, m_err, m_lut);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, act, exp);
    endtask

    // Starts a sweep; returns the edge (counted from the start edge) where
    // done was first seen, and the number of wrong lut_i steps.
    task automatic sweep(input logic [3:0] t, output int dn, output int bad);
        @(posedge clk); #2;
        tt0 = t;
        start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        dn = -1;
        bad = (lut_i0 !== 2'd0) ? 1 : 0;
        for (int e = 1; e <= 30 && dn < 0; e++) begin
            @(posedge clk); #1;
            if (done0) dn = e;
            else if (e < 20 && lut_i0 !== 2'(e / 5)) bad++;
        end
    endtask

    initial begin
        int dn, bad, ndone, d1, d2;
        bit b1, b2;
        logic i1, i2;

        #3;
        check("reset_outputs",
              int'({busy0, done0, pass0, result0, err0, lut_i0}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Identity-on-bit0 LUT: clean sweep.
        sweep(4'b1010, dn, bad);
        check("t1_done_edge", dn, 20);
        check("t1_lut_i_steps", bad, 0);
        check("t1_pass", int'(pass0), 1);
        check("t1_result", int'(result0), 'b1010);
        check("t1_err", int'(err0), 0);
        #1 abort0 = 1'b1;
        @(posedge clk); #1;
        check("t1_done_one_cycle", int'(done0), 0);
        check("t1_abort_in_done_ignored", int'(pass0), 1);
        #1 abort0 = 1'b0;

        // Bit1 LUT: two mismatches.
        sweep(4'b1100, dn, bad);
        check("t2_done_edge", dn, 20);
        check("t2_result", int'(result0), 'b1100);
        check("t2_err", int'(err0), 2);
        check("t2_pass", int'(pass0), 0);

        // abort together with start in IDLE.
        @(posedge clk); #2;
        start0 = 1'b1; abort0 = 1'b1;
        @(posedge clk); #1;
        check("idle_abort_wins", int'(busy0), 0);
        #1 start0 = 1'b0; abort0 = 1'b0;

        // Abort during vector 2 settle.
        @(posedge clk); #2;
        tt0 = 4'b1010; start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        repeat (11) @(posedge clk);
        #2 abort0 = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", int'({busy0, lut_i0, pass0}), 0);
        check("abort_partial", int'(result0[1:0]), 'b10);
        #1 abort0 = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done0) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Asynchronous reset mid-SAMPLE.
        @(posedge clk); #2;
        start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({busy0, done0, pass0, result0, err0, lut_i0}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_stays_idle", int'(busy0), 0);
        sweep(4'b1010, dn, bad);
        check("post_reset_pass", int'(pass0), 1);
        check("post_reset_done_edge", dn, 20);

        // start held high: back-to-back sweeps.
        @(posedge clk); #2;
        start0 = 1'b1;
        d1 = -1; d2 = -1; b1 = 1; b2 = 0; i1 = 1; i2 = 1;
        for (int e = 1; e <= 60 && d2 < 0; e++) begin
            @(posedge clk); #1;
            if (done0) begin
                if (d1 < 0) d1 = e;
                else d2 = e;
            end
            if (d1 > 0 && e == d1 + 1) begin b1 = busy0; i1 = lut_i0[0]; end
            if (d1 > 0 && e == d1 + 2) begin b2 = busy0; i2 = lut_i0[0]; end
        end
        #1 start0 = 1'b0;
        check("held_gap_edges", d2 - d1, 22);
        check("held_idle_cycle", int'({b1, i1}), 0);
        check("held_restart", int'({b2, i2}), 2);
        repeat (25) @(posedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            start0 = ($urandom_range(0, 5) == 0);
            abort0 = m_act && ($urandom_range(0, 30) == 0);
            if (!m_act && !m_done) tt0 = 4'($urandom);
        end
        start0 = 1'b0; abort0 = 1'b0;
        repeat (25) @(posedge clk);

        // LUT_K=3, SETTLE_CYCLES=1, XOR3.
        @(posedge clk); #2;
        start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        dn = -1;
        for (int e = 1; e <= 30 && dn < 0; e++) begin
            @(posedge clk); #1;
            if (done1) dn = e;
        end
        check("xor3_done_edge", dn, 16);
        check("xor3_pass", int'(pass1), 1);
        check("xor3_result", int'(result1), 'h96);
        check("xor3_err", int'(err1), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
